joypad_ports: RTL and testbench
===============================

JOYPAD_PORTS -- requirements
Module: joypad_ports

Interface
REQ-001 SHALL have parameter C_ports, default 2, meaning number of controller ports (1..4).
REQ-002 SHALL have parameter C_bits, default 8, meaning serial report length per port (8..24).
REQ-003 SHALL have parameter C_fill, default 1, meaning value shifted in after the report is exhausted.
REQ-004 SHALL have parameter C_external, default 0, meaning per-port bitmask [C_ports-1:0]; 1 selects the external NES pad on that port.
REQ-005 SHALL have parameter C_clk_hz, default 21428571, meaning frequency of clock.
REQ-006 SHALL have parameter C_autofire_hz, default 10, meaning turbo rate; 0 disables autofire.
REQ-007 SHALL have port clock, input, 1, meaning system clock.
REQ-008 SHALL have port R_reset, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have port joy_strobe, input, 1, meaning NES $4016 strobe.
REQ-010 SHALL have port joy_clock, input, 1, meaning NES read clock (shift on falling edge).
REQ-011 SHALL have port buttons, input, C_ports*C_bits, meaning active-high button state, port p at [p*C_bits +: C_bits].
REQ-012 SHALL have port turbo, input, 2*C_ports, meaning autofire request for A (bit 2p) and B (bit 2p+1).
REQ-013 SHALL have port ext_data, input, C_ports, meaning active-low serial data from external pads.
REQ-014 SHALL have port ext_strobe, output, 1, meaning registered joy_strobe to external pads.
REQ-015 SHALL have port ext_clock, output, 1, meaning registered joy_clock to external pads.
REQ-016 SHALL have port joy_data, output, C_ports, meaning serial bit presented to the NES, per port.
REQ-017 SHALL have port read_count, output, C_ports*5, meaning per-port count of bits shifted since the last strobe, saturating.

Function
REQ-018 SHALL register buttons, turbo, and ext_data once (one cycle of latency) before use.
REQ-019 SHALL detect a fall as last_clock=1 and joy_clock=0, with last_clock updated every cycle.
REQ-020 SHALL, while joy_strobe=1, load every cycle shreg[p] <= effective buttons and set read_count[p] <= 0.
REQ-021 SHALL define effective buttons as registered buttons, with bit 0 ORed with (turbo[2p] & phase) and bit 1 ORed with (turbo[2p+1] & phase).
REQ-022 SHALL, on a fall with joy_strobe=0, shift right: shreg[p] <= {C_fill, shreg[p][C_bits-1:1]}, read_count[p] incremented and saturating at C_bits.
REQ-023 SHALL give load priority when strobe and fall occur in the same cycle (no shift, count 0).
REQ-024 SHALL drive joy_data[p] = shreg[p][0] for an internal port; after C_bits falls it SHALL hold C_fill indefinitely.
REQ-025 SHALL, for an external port, capture joy_data[p] <= ~ext_data_reg[p] on strobe=1 or on a fall, else hold; read_count SHALL be maintained identically.
REQ-026 SHALL implement autofire with divider N = C_clk_hz/(2*C_autofire_hz): counter 0..N-1, phase toggles at N-1 and the counter wraps to 0.
REQ-027 SHALL hold phase=0 when C_autofire_hz=0, so turbo has no effect.
REQ-028 SHALL set ext_strobe and ext_clock to joy_strobe and joy_clock delayed by one cycle.

Reset
REQ-029 SHALL, while R_reset=1, clear shreg, read_count, joy_data, phase, and the divider counter, and set last_clock, ext_strobe, and ext_clock to 0.
REQ-030 SHALL ignore strobe and falls during R_reset, and SHALL produce no spurious shift on the first cycle after release if joy_clock=0.
REQ-031 SHALL, on reset mid-report, cause the next read after release to require a fresh strobe (data 0 until then).

Structure
REQ-032 SHALL place the port-index and button-bit constants (A=0, B=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7) in shared package nes_pkg.
REQ-033 SHALL contain one sub-module, joypad_shifter (one port: load, shift, saturating counter, external capture), instantiated C_ports times via generate; the autofire divider SHALL remain in the top.

Verification
REQ-034 SHALL verify: C_ports=2, C_bits=8, port0 buttons=8'h09, strobe 1->0, 8 falls -> joy_data[0] sequence 1,0,0,1,0,0,0,0, then 1 (C_fill), read_count[0]=8 saturated.
REQ-035 SHALL verify: strobe=1 and a fall in the same cycle with buttons=8'h02 -> no shift, joy_data[0]=0, read_count=0; after the next fall joy_data[0]=1.
REQ-036 SHALL verify: C_clk_hz=1000, C_autofire_hz=10, turbo[0]=1, buttons=0, strobe pulsed every cycle -> joy_data[0] toggles every 50 cycles, first 1 at cycle 51 after reset.
REQ-037 SHALL verify: C_external=2'b10, ext_data[1]=0 at strobe -> joy_data[1]=1 one cycle after registration; ext_strobe/ext_clock equal the inputs delayed by exactly 1 cycle.
REQ-038 SHALL verify: R_reset asserted after 3 falls -> all outputs 0 next cycle; after release with no strobe, falls give joy_data=0 and read_count increments from 0.
REQ-039 SHALL verify: C_bits=24, buttons=24'h800000 -> bit 1 emerges on the 24th read (after 23 falls), then C_fill.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES controller constants: port indices, button bit positions and the
// width of the per-port read counter.
package nes_pkg;

    localparam int PORT_0 = 0;
    localparam int PORT_1 = 1;
    localparam int PORT_2 = 2;
    localparam int PORT_3 = 3;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int COUNT_W = 5;

endpackage

// File: rtl/joypad_shifter.sv
// One controller port: parallel load on strobe, shift-out on read-clock falls,
// saturating read counter, or pass-through capture of an external pad.
module joypad_shifter
    import nes_pkg::*;
#(
    parameter int C_bits     = 8,
    parameter int C_fill     = 1,
    parameter bit C_external = 1'b0
) (
    input  logic                 clock,
    input  logic                 R_reset,
    input  logic                 load,
    input  logic                 fall,
    input  logic [C_bits-1:0]    eff_buttons,
    input  logic                 ext_bit,
    output logic                 joy_data,
    output logic [COUNT_W-1:0]   read_count
);

    localparam logic                FILL_BIT  = 1'(C_fill);
    localparam logic [COUNT_W-1:0]  COUNT_MAX = COUNT_W'(C_bits);

    logic [C_bits-1:0]  shreg_q, shreg_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ext_data_q, ext_data_d;

    // Load wins over a coincident fall, so a strobe never loses bit 0.
    always_comb begin
        shreg_d    = shreg_q;
        count_d    = count_q;
        ext_data_d = ext_data_q;
        if (R_reset) begin
            shreg_d    = '0;
            count_d    = '0;
            ext_data_d = 1'b0;
        end else if (load) begin
            shreg_d    = eff_buttons;
            count_d    = '0;
            ext_data_d = ~ext_bit;
        end else if (fall) begin
            shreg_d    = {FILL_BIT, shreg_q[C_bits-1:1]};
            count_d    = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
            ext_data_d = ~ext_bit;
        end
    end

    always_ff @(posedge clock) begin
        shreg_q    <= shreg_d;
        count_q    <= count_d;
        ext_data_q <= ext_data_d;
    end

    assign joy_data   = C_external ? ext_data_q : shreg_q[0];
    assign read_count = count_q;

endmodule

// File: rtl/joypad_ports.sv
// NES $4016/$4017 controller ports: input registration, read-clock fall
// detection, autofire phase divider and one shifter per port.
module joypad_ports
    import nes_pkg::*;
#(
    parameter int C_ports       = 2,
    parameter int C_bits        = 8,
    parameter int C_fill        = 1,
    parameter int C_external    = 0,
    parameter int C_clk_hz      = 21428571,
    parameter int C_autofire_hz = 10
) (
    input  logic                        clock,
    input  logic                        R_reset,
    input  logic                        joy_strobe,
    input  logic                        joy_clock,
    input  logic [C_ports*C_bits-1:0]   buttons,
    input  logic [2*C_ports-1:0]        turbo,
    input  logic [C_ports-1:0]          ext_data,
    output logic                        ext_strobe,
    output logic                        ext_clock,
    output logic [C_ports-1:0]          joy_data,
    output logic [C_ports*5-1:0]        read_count
);

    localparam int          DIV_N    = (C_autofire_hz > 0) ? C_clk_hz / (2 * C_autofire_hz) : 1;
    localparam logic [31:0] DIV_LAST = 32'(DIV_N - 1);
    localparam logic [3:0]  EXT_MASK = 4'(C_external);

    logic [C_ports*C_bits-1:0] buttons_q, buttons_d;
    logic [2*C_ports-1:0]      turbo_q, turbo_d;
    logic [C_ports-1:0]        ext_data_q, ext_data_d;
    logic                      last_clock_q, last_clock_d;
    logic                      ext_strobe_q, ext_strobe_d;
    logic                      ext_clock_q, ext_clock_d;
    logic                      phase_q, phase_d;
    logic [31:0]               div_q, div_d;
    logic                      fall;
    logic                      load;

    always_comb begin
        buttons_d    = buttons;
        turbo_d      = turbo;
        ext_data_d   = ext_data;
        last_clock_d = joy_clock;
        ext_strobe_d = joy_strobe;
        ext_clock_d  = joy_clock;
        phase_d      = phase_q;
        div_d        = div_q;
        if (R_reset) begin
            last_clock_d = 1'b0;
            ext_strobe_d = 1'b0;
            ext_clock_d  = 1'b0;
            phase_d      = 1'b0;
            div_d        = '0;
        end else if (C_autofire_hz > 0) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                phase_d = ~phase_q;
            end else begin
                div_d = div_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        buttons_q    <= buttons_d;
        turbo_q      <= turbo_d;
        ext_data_q   <= ext_data_d;
        last_clock_q <= last_clock_d;
        ext_strobe_q <= ext_strobe_d;
        ext_clock_q  <= ext_clock_d;
        phase_q      <= phase_d;
        div_q        <= div_d;
    end

    // last_clock is cleared in reset, so a low joy_clock right after release is not a fall.
    assign fall       = last_clock_q & ~joy_clock & ~R_reset;
    assign load       = joy_strobe & ~R_reset;
    assign ext_strobe = ext_strobe_q;
    assign ext_clock  = ext_clock_q;

    for (genvar p = 0; p < C_ports; p++) begin : g_port
        logic [C_bits-1:0] turbo_mask;
        logic [C_bits-1:0] eff_buttons;

        always_comb begin
            turbo_mask        = '0;
            turbo_mask[BTN_A] = turbo_q[2*p] & phase_q;
            turbo_mask[BTN_B] = turbo_q[2*p+1] & phase_q;
        end

        assign eff_buttons = buttons_q[p*C_bits +: C_bits] | turbo_mask;

        joypad_shifter #(
            .C_bits     (C_bits),
            .C_fill     (C_fill),
            .C_external (EXT_MASK[p])
        ) u_shifter (
            .clock       (clock),
            .R_reset     (R_reset),
            .load        (load),
            .fall        (fall),
            .eff_buttons (eff_buttons),
            .ext_bit     (ext_data_q[p]),
            .joy_data    (joy_data[p]),
            .read_count  (read_count[p*5 +: 5])
        );
    end

endmodule

// File: tb/tb_joypad_ports.sv
// Bench for joypad_ports: report-index reference model checked every cycle,
// a vector table for the basic read-out, and directed multi-cycle sequences.
module tb_joypad_ports;
    import nes_pkg::*;

    localparam int         P   = 2;
    localparam int         B   = 8;
    localparam int         B2  = 24;
    localparam logic [1:0] EXT = 2'b10;
    localparam int         DIV = 50;

    logic             clock = 1'b0;
    logic             R_reset = 1'b1;
    logic             joy_strobe = 1'b0;
    logic             joy_clock = 1'b0;
    logic [P*B-1:0]   buttons = '0;
    logic [2*P-1:0]   turbo = '0;
    logic [P-1:0]     ext_data = '1;
    logic             ext_strobe, ext_clock;
    logic [P-1:0]     joy_data;
    logic [P*5-1:0]   read_count;

    logic [B2-1:0]    buttons2 = 24'h800000;
    logic [1:0]       turbo2 = '0;
    logic [0:0]       ext_data2 = 1'b1;
    logic             ext_strobe2, ext_clock2;
    logic [0:0]       joy_data2;
    logic [4:0]       read_count2;

    joypad_ports #(
        .C_ports(P), .C_bits(B), .C_fill(1), .C_external(2),
        .C_clk_hz(1000), .C_autofire_hz(10)
    ) dut (
        .clock(clock), .R_reset(R_reset), .joy_strobe(joy_strobe), .joy_clock(joy_clock),
        .buttons(buttons), .turbo(turbo), .ext_data(ext_data),
        .ext_strobe(ext_strobe), .ext_clock(ext_clock),
        .joy_data(joy_data), .read_count(read_count)
    );

    joypad_ports #(
        .C_ports(1), .C_bits(B2), .C_fill(0), .C_external(0)
    ) dut24 (
        .clock(clock), .R_reset(R_reset), .joy_strobe(joy_strobe), .joy_clock(joy_clock),
        .buttons(buttons2), .turbo(turbo2), .ext_data(ext_data2),
        .ext_strobe(ext_strobe2), .ext_clock(ext_clock2),
        .joy_data(joy_data2), .read_count(read_count2)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: the latched report is indexed by the number of falls.
    logic [B-1:0] m_btn_reg [P];
    logic [1:0]   m_turbo_reg [P];
    logic         m_ext_reg [P];
    logic [B-1:0] m_report [P];
    int           m_count [P];
    logic         m_ext_out [P];
    logic         m_last = 1'b0;
    logic         m_es = 1'b0;
    logic         m_ec = 1'b0;
    int           m_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_data(input int p);
        if (EXT[p]) return m_ext_out[p];
        if (m_count[p] < B) return m_report[p][m_count[p]];
        return 1'b1;
    endfunction

    task automatic model_edge();
        logic         phase;
        logic         fall;
        logic [B-1:0] e;
        phase = ((m_cycles / DIV) % 2) == 1;
        if (R_reset) begin
            for (int p = 0; p < P; p++) begin
                m_report[p] = '0; m_count[p] = 0; m_ext_out[p] = 1'b0;
            end
            m_last = 1'b0; m_es = 1'b0; m_ec = 1'b0; m_cycles = 0;
        end else begin
            fall = m_last && !joy_clock;
            for (int p = 0; p < P; p++) begin
                if (joy_strobe) begin
                    e = m_btn_reg[p];
                    e[BTN_A] = e[BTN_A] | (m_turbo_reg[p][0] & phase);
                    e[BTN_B] = e[BTN_B] | (m_turbo_reg[p][1] & phase);
                    m_report[p] = e;
                    m_count[p] = 0;
                    m_ext_out[p] = ~m_ext_reg[p];
                end else if (fall) begin
                    m_count[p] = (m_count[p] < B) ? m_count[p] + 1 : B;
                    m_ext_out[p] = ~m_ext_reg[p];
                end
            end
            m_last = joy_clock; m_es = joy_strobe; m_ec = joy_clock;
            m_cycles++;
        end
        for (int p = 0; p < P; p++) begin
            m_btn_reg[p]   = buttons[p*B +: B];
            m_turbo_reg[p] = turbo[2*p +: 2];
            m_ext_reg[p]   = ext_data[p];
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        for (int p = 0; p < P; p++) begin
            check($sformatf("model joy_data[%0d]", p), 32'(joy_data[p]), 32'(exp_data(p)));
            check($sformatf("model read_count[%0d]", p), 32'(read_count[p*5 +: 5]), 32'(m_count[p]));
        end
        check("model ext_strobe/ext_clock", 32'({ext_strobe, ext_clock}), 32'({m_es, m_ec}));
    endtask

    task automatic do_reset();
        R_reset = 1'b1; joy_strobe = 1'b0; joy_clock = 1'b0;
        repeat (3) step();
        R_reset = 1'b0;
    endtask

    typedef struct {
        logic       strobe;
        logic       jclk;
        logic       exp_data;
        logic [4:0] exp_count;
    } vec_t;

    vec_t tbl [20];

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 1'b1, 5'd0}, '{1'b0, 1'b1, 1'b1, 5'd0},
            '{1'b0, 1'b0, 1'b0, 5'd1}, '{1'b0, 1'b1, 1'b0, 5'd1},
            '{1'b0, 1'b0, 1'b0, 5'd2}, '{1'b0, 1'b1, 1'b0, 5'd2},
            '{1'b0, 1'b0, 1'b1, 5'd3}, '{1'b0, 1'b1, 1'b1, 5'd3},
            '{1'b0, 1'b0, 1'b0, 5'd4}, '{1'b0, 1'b1, 1'b0, 5'd4},
            '{1'b0, 1'b0, 1'b0, 5'd5}, '{1'b0, 1'b1, 1'b0, 5'd5},
            '{1'b0, 1'b0, 1'b0, 5'd6}, '{1'b0, 1'b1, 1'b0, 5'd6},
            '{1'b0, 1'b0, 1'b0, 5'd7}, '{1'b0, 1'b1, 1'b0, 5'd7},
            '{1'b0, 1'b0, 1'b1, 5'd8}, '{1'b0, 1'b1, 1'b1, 5'd8},
            '{1'b0, 1'b0, 1'b1, 5'd8}, '{1'b0, 1'b1, 1'b1, 5'd8}
        };
        for (int p = 0; p < P; p++) begin
            m_btn_reg[p] = '0; m_turbo_reg[p] = '0; m_ext_reg[p] = 1'b1;
            m_report[p] = '0; m_count[p] = 0; m_ext_out[p] = 1'b0;
        end

        // Reset state
        do_reset();
        check("reset joy_data", 32'(joy_data), 32'h0);
        check("reset read_count", 32'(read_count), 32'h0);

        // Report 8'h09 read out, then fill, count saturates at 8
        buttons = 16'h0009; joy_clock = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            joy_strobe = tbl[i].strobe; joy_clock = tbl[i].jclk;
            step();
            check($sformatf("table[%0d] joy_data0", i), 32'(joy_data[0]), 32'(tbl[i].exp_data));
            check($sformatf("table[%0d] read_count0", i), 32'(read_count[4:0]), 32'(tbl[i].exp_count));
        end

        // Strobe and fall in the same cycle: load wins
        buttons = 16'h0002; joy_strobe = 1'b0; joy_clock = 1'b1;
        step();
        joy_strobe = 1'b1; joy_clock = 1'b0;
        step();
        check("same-cycle load joy_data0", 32'(joy_data[0]), 32'h0);
        check("same-cycle load read_count0", 32'(read_count[4:0]), 32'h0);
        joy_strobe = 1'b0; joy_clock = 1'b1;
        step();
        joy_clock = 1'b0;
        step();
        check("after fall joy_data0", 32'(joy_data[0]), 32'h1);
        check("after fall read_count0", 32'(read_count[4:0]), 32'h1);

        // External pad on port 1 and the one-cycle ext_strobe/ext_clock delay
        ext_data = 2'b01; joy_strobe = 1'b0; joy_clock = 1'b1;
        step();
        joy_strobe = 1'b1;
        step();
        check("ext capture joy_data1", 32'(joy_data[1]), 32'h1);
        check("ext_strobe delayed high", 32'(ext_strobe), 32'h1);
        check("ext_clock delayed high", 32'(ext_clock), 32'h1);
        ext_data = 2'b11;
        step();
        check("ext old sample joy_data1", 32'(joy_data[1]), 32'h1);
        joy_strobe = 1'b0; joy_clock = 1'b0;
        step();
        check("ext new sample joy_data1", 32'(joy_data[1]), 32'h0);
        check("ext_strobe delayed low", 32'(ext_strobe), 32'h0);
        check("ext_clock delayed low", 32'(ext_clock), 32'h0);

        // Reset mid-report, then reads without a fresh strobe
        buttons = 16'h00FF; joy_strobe = 1'b1; joy_clock = 1'b1;
        step();
        joy_strobe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            joy_clock = 1'b0; step();
            joy_clock = 1'b1; step();
        end
        R_reset = 1'b1;
        step();
        check("mid reset joy_data", 32'(joy_data), 32'h0);
        check("mid reset read_count", 32'(read_count), 32'h0);
        check("mid reset ext pins", 32'({ext_strobe, ext_clock}), 32'h0);
        R_reset = 1'b0; joy_clock = 1'b0;
        step();
        check("no spurious shift", 32'(read_count[4:0]), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            joy_clock = 1'b1; step();
            joy_clock = 1'b0; step();
            check($sformatf("post-reset fall %0d joy_data0", k), 32'(joy_data[0]), 32'h0);
            check($sformatf("post-reset fall %0d read_count0", k), 32'(read_count[4:0]), 32'(k));
        end

        // Autofire: strobe every cycle, phase flips every 50 cycles
        buttons = '0; turbo = 4'b0001;
        do_reset();
        joy_strobe = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            step();
            check($sformatf("autofire cycle %0d", k), 32'(joy_data[0]), 32'(((k - 1) / 50) % 2));
        end
        turbo = '0;

        // 24-bit report: the top bit arrives after 23 falls, then fill 0
        joy_strobe = 1'b0; joy_clock = 1'b1;
        step();
        joy_strobe = 1'b1;
        step();
        joy_strobe = 1'b0;
        step();
        check("24b load joy_data", 32'(joy_data2), 32'h0);
        check("24b load read_count", 32'(read_count2), 32'h0);
        for (int k = 1; k <= 26; k++) begin
            joy_clock = 1'b0; step();
            check($sformatf("24b fall %0d joy_data", k), 32'(joy_data2), 32'(k == 23));
            check($sformatf("24b fall %0d read_count", k), 32'(read_count2), 32'((k < 24) ? k : 24));
            joy_clock = 1'b1; step();
        end

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            R_reset    = ($urandom_range(0, 99) == 0);
            joy_strobe = ($urandom_range(0, 9) == 0);
            joy_clock  = 1'($urandom);
            buttons    = P*B'($urandom);
            turbo      = 2*P'($urandom);
            ext_data   = P'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
